// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   WORD_LEN / REG_FILE_ADDR_LEN : datapath and register-address widths
//   hz_state_e                   : memory-wait FSM states
//   hz_ctrl_t                    : bundle of pipe-register control strobes
package hazard_ctrl_pkg;

   localparam int unsigned WORD_LEN          = 32;
   localparam int unsigned REG_FILE_ADDR_LEN = 5;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MEM_WAIT = 1'b1
   } hz_state_e;

   typedef struct packed {
      logic pc_freeze;
      logic if_id_freeze;
      logic if_id_flush;
      logic id_exe_bubble;
      logic back_freeze;
      logic mem_wb_bubble;
   } hz_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_sat.sv
// Saturating up-counter.
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count this cycle
//   q        : current count, holds at all-ones
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Decides each cycle whether PC and the pipe registers advance, freeze or
// take a bubble, from ID-stage RAW hazards, taken branches and data-memory
// wait states.
//   Inputs : fwd_en, ID sources, EXE/MEM destinations and write-enables,
//            exe_mem_read, mem_req/mem_ready, branch_taken
//   Outputs: pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble,
//            back_freeze, mem_wb_bubble (all combinational, zero latency),
//            timeout_err (sticky), stall_cycles / flush_count (saturating)
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         fwd_en,
   input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
   input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
   input  logic                         id_two_src,
   input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
   input  logic                         exe_wb_en,
   input  logic                         exe_mem_read,
   input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
   input  logic                         mem_wb_en,
   input  logic                         mem_req,
   input  logic                         mem_ready,
   input  logic                         branch_taken,
   output logic                         pc_freeze,
   output logic                         if_id_freeze,
   output logic                         if_id_flush,
   output logic                         id_exe_bubble,
   output logic                         back_freeze,
   output logic                         mem_wb_bubble,
   output logic                         timeout_err,
   output logic [CNT_W-1:0]             stall_cycles,
   output logic [CNT_W-1:0]             flush_count
);

   // Wide enough to hold MEM_TIMEOUT-1.
   localparam int unsigned WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MEM_TIMEOUT - 1);

   hz_state_e       state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   logic     exe_hit, mem_hit, hazard, mem_stall;
   hz_ctrl_t ctrl;

   // RAW hit terms; r0 is never a real dependency.
   assign exe_hit = exe_wb_en && (exe_dest != '0) &&
                    ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
   assign mem_hit = mem_wb_en && (mem_dest != '0) &&
                    ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign hazard = fwd_en ? (exe_hit && exe_mem_read) : (exe_hit || mem_hit);

   // A request that is not ready in its own cycle stalls immediately, so N
   // wait cycles give exactly N freeze cycles.
   assign mem_stall = ((state_q == HZ_RUN) && mem_req && !mem_ready) ||
                      ((state_q == HZ_MEM_WAIT) && !mem_ready);

   always_comb begin
      ctrl = '0;
      if (mem_stall) begin
         ctrl.pc_freeze     = 1'b1;
         ctrl.if_id_freeze  = 1'b1;
         ctrl.back_freeze   = 1'b1;
         ctrl.mem_wb_bubble = 1'b1;
      end else if (hazard) begin
         // No flush here: the branch is re-evaluated once operands are valid.
         ctrl.pc_freeze     = 1'b1;
         ctrl.if_id_freeze  = 1'b1;
         ctrl.id_exe_bubble = 1'b1;
      end else if (branch_taken) begin
         ctrl.if_id_flush   = 1'b1;
      end
   end

   assign pc_freeze     = ctrl.pc_freeze;
   assign if_id_freeze  = ctrl.if_id_freeze;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_exe_bubble = ctrl.id_exe_bubble;
   assign back_freeze   = ctrl.back_freeze;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;

   // Next state, watchdog and sticky timeout.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         HZ_RUN: begin
            wait_cnt_d = '0;
            if (mem_req && !mem_ready)
               state_d = HZ_MEM_WAIT;
         end
         HZ_MEM_WAIT: begin
            if (wait_cnt_q != WAIT_MAX)
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            if (mem_ready)
               state_d = HZ_RUN;
            else if (wait_cnt_d == WAIT_MAX)
               timeout_err_d = 1'b1;
         end
         default: begin
            state_d    = HZ_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= HZ_RUN;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ctrl.pc_freeze),
      .q   (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ctrl.if_id_flush),
      .q   (flush_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (MEM_TIMEOUT=4/CNT_W=4
// and the defaults) share one stimulus stream and are compared against a
// behavioural model of the sequencing rules.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fwd_en, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
   logic       mem_req, mem_ready, branch_taken;
   logic [4:0] id_src1, id_src2, exe_dest, mem_dest;

   logic        a_pcf, a_iff, a_ifl, a_bub, a_bkf, a_mwb, a_tmo;
   logic [3:0]  a_stall, a_flush;
   logic        b_pcf, b_iff, b_ifl, b_bub, b_bkf, b_mwb, b_tmo;
   logic [15:0] b_stall, b_flush;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Model state: outstanding access, consecutive stall run, totals.
   bit          m_busy;
   int unsigned m_run, m_stall_tot, m_flush_tot;
   bit          m_tmo_a, m_tmo_b;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .pc_freeze(a_pcf), .if_id_freeze(a_iff), .if_id_flush(a_ifl),
      .id_exe_bubble(a_bub), .back_freeze(a_bkf), .mem_wb_bubble(a_mwb),
      .timeout_err(a_tmo), .stall_cycles(a_stall), .flush_count(a_flush)
   );

   hazard_ctrl dut_b (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .pc_freeze(b_pcf), .if_id_freeze(b_iff), .if_id_flush(b_ifl),
      .id_exe_bubble(b_bub), .back_freeze(b_bkf), .mem_wb_bubble(b_mwb),
      .timeout_err(b_tmo), .stall_cycles(b_stall), .flush_count(b_flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int unsigned satv(input int unsigned v, input int unsigned w);
      int unsigned lim;
      lim = (32'd1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit model_mem_stall();
      return !mem_ready && (m_busy || mem_req);
   endfunction

   // Expected {pc_freeze, if_id_freeze, if_id_flush, id_exe_bubble, back_freeze, mem_wb_bubble}.
   function automatic logic [5:0] exp_ctrl();
      bit e_hit, m_hit, hz;
      e_hit = exe_wb_en && exe_dest != 0 &&
              (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
      m_hit = mem_wb_en && mem_dest != 0 &&
              (mem_dest == id_src1 || (id_two_src && mem_dest == id_src2));
      hz = fwd_en ? (e_hit && exe_mem_read) : (e_hit || m_hit);
      if (model_mem_stall()) return 6'b110011;
      if (hz)                return 6'b110100;
      if (branch_taken)      return 6'b001000;
      return 6'b000000;
   endfunction

   task automatic set_idle();
      fwd_en = 1'b1; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
      exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_dest = '0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      branch_taken = 1'b0;
   endtask

   // Called at posedge+1 with inputs already applied; returns at next posedge+1.
   task automatic step();
      logic [5:0] e;
      bit         ms;
      #1;
      e = exp_ctrl();
      chk("ctrl_a", {26'd0, a_pcf, a_iff, a_ifl, a_bub, a_bkf, a_mwb}, {26'd0, e});
      chk("ctrl_b", {26'd0, b_pcf, b_iff, b_ifl, b_bub, b_bkf, b_mwb}, {26'd0, e});
      chk("stall_a", {28'd0, a_stall}, satv(m_stall_tot, 4));
      chk("flush_a", {28'd0, a_flush}, satv(m_flush_tot, 4));
      chk("stall_b", {16'd0, b_stall}, satv(m_stall_tot, 16));
      chk("flush_b", {16'd0, b_flush}, satv(m_flush_tot, 16));
      chk("tmo_a", {31'd0, a_tmo}, {31'd0, m_tmo_a});
      chk("tmo_b", {31'd0, b_tmo}, {31'd0, m_tmo_b});
      ms = model_mem_stall();
      @(posedge clk);
      if (e[5]) m_stall_tot++;
      if (e[3]) m_flush_tot++;
      m_run = ms ? m_run + 1 : 0;
      if (ms && m_run >= 4)   m_tmo_a = 1'b1;
      if (ms && m_run >= 255) m_tmo_b = 1'b1;
      m_busy = ms;
      #1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      #1;
      // Idle inputs with mem_ready low: any leftover MEM_WAIT would stall.
      chk("rst_ctrl_a", {26'd0, a_pcf, a_iff, a_ifl, a_bub, a_bkf, a_mwb}, 32'd0);
      chk("rst_ctrl_b", {26'd0, b_pcf, b_iff, b_ifl, b_bub, b_bkf, b_mwb}, 32'd0);
      chk("rst_cnt_a", {24'd0, a_stall, a_flush}, 32'd0);
      chk("rst_cnt_b", {b_stall, b_flush}, 32'd0);
      chk("rst_tmo", {30'd0, a_tmo, b_tmo}, 32'd0);
      m_busy = 1'b0; m_run = 0; m_stall_tot = 0; m_flush_tot = 0;
      m_tmo_a = 1'b0; m_tmo_b = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      #2;
      do_reset();

      // Load-use with forwarding: one bubble, then clear.
      fwd_en = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd3; id_src1 = 5'd3;
      step();
      exe_wb_en = 1'b0; exe_mem_read = 1'b0; mem_wb_en = 1'b1; mem_dest = 5'd3;
      step();
      chk("lu_stall_cnt", {16'd0, b_stall}, 32'd1);

      // No forwarding: MEM writer hits src2 only when src2 is read; r0 never hits.
      do_reset();
      fwd_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 5'd5; id_src2 = 5'd5; id_two_src = 1'b1;
      step(); step();
      id_two_src = 1'b0;
      step();
      mem_dest = 5'd0; id_src1 = 5'd0; id_two_src = 1'b1; id_src2 = 5'd0;
      exe_wb_en = 1'b1; exe_dest = 5'd0;
      step();
      chk("nofwd_stall_cnt", {16'd0, b_stall}, 32'd2);

      // Three wait cycles then ready; then a zero-wait access.
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      step(); mem_req = 1'b0; step(); step();
      mem_ready = 1'b1;
      step();
      chk("wait3_cnt", {16'd0, b_stall}, 32'd3);
      mem_req = 1'b1; mem_ready = 1'b1;
      step();
      chk("wait0_cnt", {16'd0, b_stall}, 32'd3);

      // Branch with load-use hazard defers the flush; then flush alone.
      do_reset();
      fwd_en = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 5'd7;
      id_src1 = 5'd7; branch_taken = 1'b1;
      step();
      exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      step();
      chk("br_flush_cnt", {16'd0, b_flush}, 32'd1);

      // Timeout on the small instance, reset mid-wait, then long wait for defaults.
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         mem_req = 1'b0;
      end
      chk("tmo_small", {31'd0, a_tmo}, 32'd1);
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 260; i++) begin
         step();
         mem_req = 1'b0;
      end
      mem_ready = 1'b1;
      step(); step();
      chk("tmo_big_sticky", {31'd0, b_tmo}, 32'd1);
      chk("sat_small", {28'd0, a_stall}, 32'd15);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ((i % 400) == 399) do_reset();
         if ($urandom_range(0, 31) == 0) fwd_en = 1'($urandom_range(0, 1));
         id_src1      = 5'($urandom_range(0, 3));
         id_src2      = 5'($urandom_range(0, 3));
         id_two_src   = 1'($urandom_range(0, 1));
         exe_dest     = 5'($urandom_range(0, 3));
         exe_wb_en    = 1'($urandom_range(0, 1));
         exe_mem_read = 1'($urandom_range(0, 1));
         mem_dest     = 5'($urandom_range(0, 3));
         mem_wb_en    = 1'($urandom_range(0, 1));
         mem_req      = ($urandom_range(0, 2) == 0);
         mem_ready    = ($urandom_range(0, 3) != 0);
         branch_taken = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
